axi_lite_mem_slave: RTL and testbench

AXI4-Lite responder backed by a word-addressed memory array: the slave end of the data and instruction AXI ports driven by `riscv_top`. One instance per master port (data, instruction) gives the core a synthesizable memory target for simulation and FPGA bring-up. Read and write channels run independent state machines over a shared array with byte-strobe writes.

---
 rtl/axi_lite_mem_slave_pkg.sv | 18 +
 rtl/axi_lite_mem_slave_if.sv | 35 +++
 rtl/axi_mem_array.sv | 52 +++++
 rtl/axi_lite_mem_slave.sv | 187 ++++++++++++++++++
 tb/tb_axi_lite_mem_slave.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the memory responder.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle (no prot signals) with master/slave views.
interface axi_lite_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_mem_array.sv
// Word-addressed 32-bit storage: one byte-enabled write port, one registered read port.
module axi_mem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_be,
    input  logic             rd_en,
    input  logic             rd_zero,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_d;
    logic [31:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto block RAM and keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // NOTE: default first so every path assigns rd_data_d and no latch is inferred.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_zero ? 32'h0 : mem[rd_idx];
        end
    end

    // NOTE: non-blocking so every flop samples pre-edge values, which gives read-old-data on a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 32'h0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory responder with independent read/write FSMs over a shared array.
// Define AXI_MEM_ERR_EN to answer out-of-window accesses with DECERR instead of wrapping.
module axi_lite_mem_slave
    import axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input logic                  axi_clk,
    input logic                  rst,
    axi_lite_mem_slave_if.slave  s_axi
);

    localparam int                  IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] SPAN_BYTES = (ADDR_WIDTH + 1)'(DEPTH_WORDS) << 2;
`ifdef AXI_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    w_state_e                w_state_q, w_state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic [1:0]              bresp_q, bresp_d;

    r_state_e                r_state_q, r_state_d;
    logic                    arready_q, arready_d;
    logic [1:0]              rresp_q, rresp_d;

    logic                    aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0]   wr_addr, wr_off, rd_off;
    logic                    wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic                    mem_we, mem_rd_en;
    logic [31:0]             mem_rd_data;

    assign aw_hs = s_axi.awvalid && awready_q;
    assign w_hs  = s_axi.wvalid && wready_q;
    assign ar_hs = s_axi.arvalid && arready_q;

    // Address decode; the write side uses the beat arriving this cycle or the latched one.
    always_comb begin
        wr_addr = aw_hs ? s_axi.awaddr : awaddr_q;
        wr_data = w_hs ? s_axi.wdata : wdata_q;
        wr_be   = w_hs ? s_axi.wstrb : wstrb_q;
        wr_off  = wr_addr - BASE_ADDR;
        rd_off  = s_axi.araddr - BASE_ADDR;
        wr_ok   = !ERR_EN || ((wr_addr >= BASE_ADDR) && ({1'b0, wr_off} < SPAN_BYTES));
        rd_ok   = !ERR_EN || ((s_axi.araddr >= BASE_ADDR) && ({1'b0, rd_off} < SPAN_BYTES));
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi.wdata;
                    wstrb_d  = s_axi.wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    mem_we    = wr_ok;
                    bresp_d   = wr_ok ? RESP_OKAY : RESP_DECERR;
                end else begin
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_state_d = W_IDLE;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rresp_d   = rresp_q;
        mem_rd_en = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    mem_rd_en = 1'b1;
                    rresp_d   = rd_ok ? RESP_OKAY : RESP_DECERR;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rresp_q   <= rresp_d;
        end
    end

    axi_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk     (axi_clk),
        .rst     (rst),
        .we      (mem_we),
        .wr_idx  (wr_off[IDX_W+1:2]),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .rd_en   (mem_rd_en),
        .rd_zero (!rd_ok),
        .rd_idx  (rd_off[IDX_W+1:2]),
        .rd_data (mem_rd_data)
    );

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = (w_state_q == W_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = (r_state_q == R_DATA);
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = mem_rd_data;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave: drivers queue expected B/R responses, a monitor checks them.
module tb_axi_lite_mem_slave;
    import axi_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

`ifdef AXI_MEM_ERR_EN
    localparam logic [31:0] EXP_OOR_DATA = 32'h0000_0000;
    localparam logic [1:0]  EXP_OOR_RESP = RESP_DECERR;
    localparam logic [31:0] EXP_WORD0    = 32'hCAFE_F00D;
`else
    localparam logic [31:0] EXP_OOR_DATA = 32'h1234_5678;
    localparam logic [1:0]  EXP_OOR_RESP = RESP_OKAY;
    localparam logic [31:0] EXP_WORD0    = 32'h1234_5678;
`endif

    logic axi_clk = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    logic [1:0] b_q [$];
    r_exp_t     r_q [$];
    r_exp_t     r_cur;

    always #5 axi_clk = ~axi_clk;

    axi_lite_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_mem_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (32'h0)
    ) dut (
        .axi_clk (axi_clk),
        .rst     (rst),
        .s_axi   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    // Monitor: compares every B/R handshake against the head of its queue.
    always @(negedge axi_clk) begin
        if (!rst) begin
            if (bus.bvalid && bus.bready) begin
                if (b_q.size() == 0) fail_now("b_unexpected");
                else check("bresp", 64'(bus.bresp), 64'(b_q.pop_front()));
            end
            if (bus.rvalid && bus.rready) begin
                if (r_q.size() == 0) fail_now("r_unexpected");
                else begin
                    r_cur = r_q.pop_front();
                    check("rdata", 64'(bus.rdata), 64'(r_cur.data));
                    check("rresp", 64'(bus.rresp), 64'(r_cur.resp));
                end
            end
        end
    end

    task automatic write_issue(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs, w_hs;
        int n = 0;
        b_q.push_back(resp);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge axi_clk);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            tick();
            n++;
            if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
        end
        if (!(aw_done && w_done)) fail_now("write_accept_timeout");
        else check("b_latency", 64'(bus.bvalid), 64'(1));
    endtask

    task automatic wait_b_done();
        int n = 0;
        while (bus.bvalid && n < 20) begin tick(); n++; end
        if (bus.bvalid) fail_now("b_timeout");
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
        write_issue(addr, data, strb, resp);
        wait_b_done();
    endtask

    task automatic read_issue(input logic [31:0] addr);
        bit done = 1'b0;
        bit hs;
        int n = 0;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!done && n < 20) begin
            @(negedge axi_clk);
            hs = bus.arvalid && bus.arready;
            tick();
            n++;
            if (hs) begin bus.arvalid = 1'b0; done = 1'b1; end
        end
        if (!done) fail_now("read_accept_timeout");
        else check("r_latency", 64'(bus.rvalid), 64'(1));
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        r_q.push_back('{data: data, resp: resp});
        read_issue(addr);
        while (bus.rvalid && n < 20) begin tick(); n++; end
        if (bus.rvalid) fail_now("r_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;

        // Reset values, then readys rise one cycle after release.
        repeat (3) tick();
        @(negedge axi_clk);
        check("rst_ctrl", 64'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}), 64'(0));
        check("rst_resp", 64'({bus.bresp, bus.rresp}), 64'(0));
        check("rst_rdata", 64'(bus.rdata), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge axi_clk);
        check("ready_pre_rise", 64'({bus.awready, bus.wready, bus.arready}), 64'(0));
        tick();
        check("ready_rise", 64'({bus.awready, bus.wready, bus.arready}), 64'(3'b111));

        // AW+W together, then read back.
        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, RESP_OKAY);
        axi_read(32'h10, 32'hDEAD_BEEF, RESP_OKAY);

        // W two cycles ahead of AW, partial strobes over all-ones.
        axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, RESP_OKAY);
        b_q.push_back(RESP_OKAY);
        bus.wdata  = 32'h1122_3344;
        bus.wstrb  = 4'b0101;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        @(negedge axi_clk);
        check("w_only_readys", 64'({bus.awready, bus.wready, bus.bvalid}), 64'(3'b100));
        tick();
        bus.awaddr  = 32'h20;
        bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("b_latency_split", 64'(bus.bvalid), 64'(1));
        wait_b_done();
        axi_read(32'h20, 32'hFF22_FF44, RESP_OKAY);

        // Back-pressure on B for five cycles.
        bus.bready = 1'b0;
        write_issue(32'h40, 32'h0BAD_CAFE, 4'hF, RESP_OKAY);
        repeat (5) begin
            @(negedge axi_clk);
            check("b_hold", 64'({bus.bvalid, bus.bresp, bus.awready, bus.wready}), 64'(5'b1_00_00));
        end
        tick();
        bus.bready = 1'b1;
        tick();
        check("ready_after_b", 64'({bus.bvalid, bus.awready, bus.wready}), 64'(3'b011));
        axi_read(32'h40, 32'h0BAD_CAFE, RESP_OKAY);

        // Read and write commit to the same word on the same edge.
        axi_write(32'h30, 32'hA5A5_A5A5, 4'hF, RESP_OKAY);
        b_q.push_back(RESP_OKAY);
        r_q.push_back('{data: 32'hA5A5_A5A5, resp: RESP_OKAY});
        bus.awaddr  = 32'h30;
        bus.wdata   = 32'h5A5A_5A5A;
        bus.wstrb   = 4'hF;
        bus.araddr  = 32'h30;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.arvalid = 1'b1;
        @(negedge axi_clk);
        check("ready_all", 64'({bus.awready, bus.wready, bus.arready}), 64'(3'b111));
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        check("coincident_valid", 64'({bus.bvalid, bus.rvalid}), 64'(2'b11));
        tick();
        tick();
        axi_read(32'h30, 32'h5A5A_5A5A, RESP_OKAY);

        // One past the window, then reset while a read response is pending.
        axi_write(32'h0, 32'hCAFE_F00D, 4'hF, RESP_OKAY);
        axi_write(32'h4000, 32'h1234_5678, 4'hF, EXP_OOR_RESP);
        axi_read(32'h4000, EXP_OOR_DATA, EXP_OOR_RESP);
        bus.rready = 1'b0;
        read_issue(32'h0);
        tick();
        @(negedge axi_clk);
        check("rvalid_hold", 64'({bus.rvalid, bus.rresp}), 64'(3'b1_00));
        check("rdata_hold", 64'(bus.rdata), 64'(EXP_WORD0));
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_rvalid", 64'({bus.rvalid, bus.bvalid}), 64'(0));
        check("rst_mid_rdata", 64'(bus.rdata), 64'(0));
        rst        = 1'b0;
        bus.rready = 1'b1;
        tick();
        check("ready_after_rst", 64'({bus.awready, bus.wready, bus.arready}), 64'(3'b111));
        axi_read(32'h0, EXP_WORD0, RESP_OKAY);
        axi_read(32'h10, 32'hDEAD_BEEF, RESP_OKAY);

        tick();
        check("b_q_empty", 64'(b_q.size()), 64'(0));
        check("r_q_empty", 64'(r_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
